// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - Pipeline register stage with optional two-entry skid buffer
module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    logic              accept;
    logic              consume;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              valid_q;
    logic [1:0]        occ_q;

    assign accept    = in_valid && in_ready;
    assign consume   = valid_q && out_ready;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;
    assign out_valid = valid_q;
    assign occupancy = occ_q;

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

            state_t            state;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;

            // Readiness depends only on registered state, breaking the out_ready path.
            assign in_ready = (state != TWO) && !flush && resetn;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    state     <= EMPTY;
                    main_data <= '0;
                    main_ctrl <= '0;
                    skid_data <= '0;
                    skid_ctrl <= '0;
                    valid_q   <= 1'b0;
                    occ_q     <= 2'd0;
                end else if (flush) begin
                    state     <= EMPTY;
                    main_ctrl <= '0;
                    skid_ctrl <= '0;
                    valid_q   <= 1'b0;
                    occ_q     <= 2'd0;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (accept) begin
                                main_data <= in_data;
                                main_ctrl <= in_ctrl;
                                valid_q   <= 1'b1;
                                occ_q     <= 2'd1;
                                state     <= ONE;
                            end
                        end
                        ONE: begin
                            if (accept && !consume) begin
                                skid_data <= in_data;
                                skid_ctrl <= in_ctrl;
                                occ_q     <= 2'd2;
                                state     <= TWO;
                            end else if (accept && consume) begin
                                main_data <= in_data;
                                main_ctrl <= in_ctrl;
                            end else if (consume) begin
                                main_ctrl <= '0;
                                valid_q   <= 1'b0;
                                occ_q     <= 2'd0;
                                state     <= EMPTY;
                            end
                        end
                        TWO: begin
                            if (consume) begin
                                main_data <= skid_data;
                                main_ctrl <= skid_ctrl;
                                skid_ctrl <= '0;
                                occ_q     <= 2'd1;
                                state     <= ONE;
                            end
                        end
                        default: begin
                            main_ctrl <= '0;
                            skid_ctrl <= '0;
                            valid_q   <= 1'b0;
                            occ_q     <= 2'd0;
                            state     <= EMPTY;
                        end
                    endcase
                end
            end
        end else begin : g_single
            assign in_ready = (!valid_q || out_ready) && !flush && resetn;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    main_data <= '0;
                    main_ctrl <= '0;
                    valid_q   <= 1'b0;
                    occ_q     <= 2'd0;
                end else if (flush) begin
                    main_ctrl <= '0;
                    valid_q   <= 1'b0;
                    occ_q     <= 2'd0;
                end else if (accept) begin
                    // Covers accept+consume too: the departing entry is replaced in place.
                    main_data <= in_data;
                    main_ctrl <= in_ctrl;
                    valid_q   <= 1'b1;
                    occ_q     <= 2'd1;
                end else if (consume) begin
                    main_ctrl <= '0;
                    valid_q   <= 1'b0;
                    occ_q     <= 2'd0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - Scoreboard bench for pipe_stage_reg, SKID=0 and SKID=1 side by side
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic [15:0] in_data;
    logic [7:0]  in_ctrl;
    logic        flush;
    logic        out_ready;

    logic [1:0]  in_rdy;
    logic [1:0]  out_vld;
    logic [15:0] out_dat [2];
    logic [7:0]  out_ctl [2];
    logic [1:0]  occ [2];

    int n_chk  = 0;
    int n_fail = 0;
    int deliv [2];
    logic [23:0] q [2][$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .SKID(0)) dut0 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_rdy[0]),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_vld[0]),
        .out_ready(out_ready), .out_data(out_dat[0]), .out_ctrl(out_ctl[0]),
        .occupancy(occ[0])
    );

    pipe_stage_reg #(.DATA_W(16), .CTRL_W(8), .SKID(1)) dut1 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_rdy[1]),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_vld[1]),
        .out_ready(out_ready), .out_data(out_dat[1]), .out_ctrl(out_ctl[1]),
        .occupancy(occ[1])
    );

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL skid%0d %s: got %0h expected %0h at %0t", d, nm, act, exp, $time);
        end
    endtask

    // Reference: each stage is a FIFO of capacity 1 (SKID=0) or 2 (SKID=1).
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic        er;
            logic [23:0] e;
            if (!resetn) begin
                chk("rst_occ", d, occ[d], 0);
                chk("rst_valid", d, out_vld[d], 0);
                chk("rst_ctrl", d, out_ctl[d], 0);
                chk("rst_data", d, out_dat[d], 0);
                chk("rst_ready", d, in_rdy[d], 0);
                q[d].delete();
            end else begin
                if (d == 1) er = !flush && (q[d].size() < 2);
                else        er = !flush && (q[d].size() == 0 || out_ready);
                chk("in_ready", d, in_rdy[d], er);
                chk("occupancy", d, occ[d], q[d].size());
                chk("out_valid", d, out_vld[d], q[d].size() != 0);
                if (q[d].size() == 0) begin
                    chk("bubble_ctrl", d, out_ctl[d], 0);
                end else begin
                    e = q[d][0];
                    chk("out_data", d, out_dat[d], e[23:8]);
                    chk("out_ctrl", d, out_ctl[d], e[7:0]);
                    if (out_ready) begin
                        void'(q[d].pop_front());
                        deliv[d]++;
                    end
                end
                if (in_valid && er) q[d].push_back({in_data, in_ctrl});
                if (flush) q[d].delete();
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v, input int d);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        in_ctrl  = 8'($urandom_range(1, 255));
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_rdy[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", d, 0, 1);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int d0;
        resetn = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        flush = 1'b0; out_ready = 1'b0;
        deliv[0] = 0; deliv[1] = 0;
        repeat (2) step();
        resetn = 1'b1;

        // Streaming 1..8 at full rate
        out_ready = 1'b1;
        d0 = deliv[1];
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 16'(i); in_ctrl = 8'($urandom);
            step();
        end
        in_valid = 1'b0;
        step(); step();
        chk("stream_count", 1, deliv[1] - d0, 8);

        // Backpressure A, B, C
        out_ready = 1'b0;
        send(16'hA, 1);
        send(16'hB, 1);
        in_valid = 1'b1; in_data = 16'hC; in_ctrl = 8'h3C;
        @(negedge clk);
        chk("bp_c_ready", 1, in_rdy[1], 0);
        chk("bp_occ", 1, occ[1], 2);
        chk("bp_head", 1, out_dat[1], 16'hA);
        step();
        out_ready = 1'b1;
        send(16'hC, 1);
        repeat (3) step();

        // Flush with a full skid stage
        out_ready = 1'b0;
        send(16'h1, 1);
        send(16'h2, 1);
        @(negedge clk);
        chk("fl_occ_pre", 1, occ[1], 2);
        step();
        flush = 1'b1; in_valid = 1'b1; in_data = 16'hEE; in_ctrl = 8'h77;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("fl_occ", 1, occ[1], 0);
        chk("fl_valid", 1, out_vld[1], 0);
        chk("fl_ctrl", 1, out_ctl[1], 0);
        chk("fl_ready", 1, in_rdy[1], 1);
        step();
        out_ready = 1'b1;
        repeat (3) step();

        // Asynchronous reset mid-backpressure
        out_ready = 1'b0;
        send(16'h3, 1);
        send(16'h4, 1);
        #2 resetn = 1'b0;
        #1;
        chk("ar_occ", 1, occ[1], 0);
        chk("ar_valid", 1, out_vld[1], 0);
        chk("ar_ctrl", 1, out_ctl[1], 0);
        step();
        resetn = 1'b1;
        step();

        // Single-register replace under consume
        out_ready = 1'b0;
        send(16'h3, 0);
        @(negedge clk);
        chk("s0_blocked", 0, in_rdy[0], 0);
        step();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h5; in_ctrl = 8'h55;
        @(negedge clk);
        chk("s0_ready", 0, in_rdy[0], 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("s0_data", 0, out_dat[0], 16'h5);
        chk("s0_valid", 0, out_vld[0], 1);
        step();

        // Bubbles with all-ones control on the input
        in_valid = 1'b0; in_ctrl = 8'hFF;
        repeat (3) step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bub_ctrl", 1, out_ctl[1], 0);
            chk("bub_valid", 1, out_vld[1], 0);
            step();
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 16'($urandom);
            in_ctrl   = 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            resetn    = ($urandom_range(0, 99) != 0);
            step();
        end
        resetn = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
